// File: rtl/binary2unary.sv
// Purpose: registered binary-to-thermometer encoder with direct (valid/ready) and ramp-sweep modes.
// Latency: 1 cycle from an accepted direct code or a RAMP step to unary/out_valid.
// Backpressure: in_ready is low outside IDLE, while ramp_start is high, and while rst_n is low.
//
// Ports:
//   clk, rst_n              rising-edge clock, asynchronous active-low reset
//   in_code/in_valid/in_ready  direct-mode code handshake (accepted in IDLE only)
//   ramp_start, ramp_abort  start a sweep from IDLE / drop back to IDLE mid-sweep
//   dwell                   extra hold cycles per ramp code, latched at ramp start
//   unary                   thermometer word, bits [k-1:0] set for code k
//   out_valid, sat          one-cycle pulses: unary updated / direct code was clamped
//   ramp_busy, ramp_done    sweep in progress / one-cycle pulse when the sweep completes
module binary2unary #(
    parameter int unary_width = 255,
    parameter int bin_width   = 8,
    parameter int dwell_width = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [bin_width-1:0]   in_code,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   ramp_start,
    input  logic                   ramp_abort,
    input  logic [dwell_width-1:0] dwell,
    output logic [unary_width-1:0] unary,
    output logic                   out_valid,
    output logic                   sat,
    output logic                   ramp_busy,
    output logic                   ramp_done
);

    typedef enum logic [1:0] {IDLE, RAMP, DWELL} state_t;

    // Counter is one bit wider than the code so a full 2**bin_width-1 sweep never wraps.
    localparam logic [bin_width:0] UMAX = (bin_width + 1)'(unary_width);

    state_t                 state, state_nxt;
    logic [bin_width:0]     cnt, cnt_nxt;
    logic [dwell_width-1:0] dwell_lat, dwell_lat_nxt;
    logic [dwell_width-1:0] dcnt, dcnt_nxt;
    logic [unary_width-1:0] unary_nxt;
    logic                   out_valid_nxt;
    logic                   sat_nxt;
    logic                   ramp_done_nxt;
    logic [bin_width:0]     code_ext;

    function automatic logic [unary_width-1:0] therm(input logic [bin_width:0] c);
        logic [unary_width-1:0] t;
        t = '0;
        for (int i = 0; i < unary_width; i++) begin
            t[i] = (i < int'(c));
        end
        return t;
    endfunction

    // Gate with rst_n so the upstream never sees ready while the block is held in reset.
    assign in_ready  = rst_n && (state == IDLE) && !ramp_start;
    assign ramp_busy = (state != IDLE);
    assign code_ext  = {1'b0, in_code};

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        dwell_lat_nxt = dwell_lat;
        dcnt_nxt      = dcnt;
        unary_nxt     = unary;
        out_valid_nxt = 1'b0;
        sat_nxt       = 1'b0;
        ramp_done_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (ramp_start) begin
                    dwell_lat_nxt = dwell;
                    cnt_nxt       = '0;
                    state_nxt     = RAMP;
                end else if (in_valid) begin
                    out_valid_nxt = 1'b1;
                    if (code_ext > UMAX) begin
                        unary_nxt = therm(UMAX);
                        sat_nxt   = 1'b1;
                    end else begin
                        unary_nxt = therm(code_ext);
                    end
                end
            end
            RAMP: begin
                if (ramp_abort) begin
                    state_nxt = IDLE;
                end else begin
                    unary_nxt     = therm(cnt);
                    out_valid_nxt = 1'b1;
                    if (dwell_lat == '0) begin
                        if (cnt == UMAX) begin
                            ramp_done_nxt = 1'b1;
                            state_nxt     = IDLE;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end else begin
                        dcnt_nxt  = dwell_lat;
                        state_nxt = DWELL;
                    end
                end
            end
            DWELL: begin
                if (ramp_abort) begin
                    state_nxt = IDLE;
                end else begin
                    dcnt_nxt = dcnt - 1'b1;
                    // RAMP cycle plus dwell DWELL cycles gives dwell+1 cycles per code.
                    if (dcnt <= 1) begin
                        if (cnt == UMAX) begin
                            ramp_done_nxt = 1'b1;
                            state_nxt     = IDLE;
                        end else begin
                            cnt_nxt   = cnt + 1'b1;
                            state_nxt = RAMP;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            dwell_lat <= '0;
            dcnt      <= '0;
            unary     <= '0;
            out_valid <= 1'b0;
            sat       <= 1'b0;
            ramp_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            dwell_lat <= dwell_lat_nxt;
            dcnt      <= dcnt_nxt;
            unary     <= unary_nxt;
            out_valid <= out_valid_nxt;
            sat       <= sat_nxt;
            ramp_done <= ramp_done_nxt;
        end
    end

endmodule

// File: tb/tb_binary2unary.sv
module tb_binary2unary;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    // Main instance: unary_width 255
    logic [7:0]   in_code = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         ramp_start = 1'b0;
    logic         ramp_abort = 1'b0;
    logic [7:0]   dwell = '0;
    logic [254:0] unary;
    logic         out_valid, sat, ramp_busy, ramp_done;

    // Saturation instance: unary_width 200
    logic [7:0]   in_code2 = '0;
    logic         in_valid2 = 1'b0;
    logic         in_ready2;
    logic [199:0] unary2;
    logic         out_valid2, sat2, ramp_busy2, ramp_done2;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    binary2unary #(.unary_width(255), .bin_width(8), .dwell_width(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_valid(in_valid), .in_ready(in_ready),
        .ramp_start(ramp_start), .ramp_abort(ramp_abort), .dwell(dwell),
        .unary(unary), .out_valid(out_valid), .sat(sat), .ramp_busy(ramp_busy), .ramp_done(ramp_done)
    );

    binary2unary #(.unary_width(200), .bin_width(8), .dwell_width(8)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_code(in_code2), .in_valid(in_valid2), .in_ready(in_ready2),
        .ramp_start(1'b0), .ramp_abort(1'b0), .dwell(8'd0),
        .unary(unary2), .out_valid(out_valid2), .sat(sat2), .ramp_busy(ramp_busy2), .ramp_done(ramp_done2)
    );

    // Reference: code k (clamped to w) -> low k bits set
    function automatic logic [255:0] therm_ref(input int code, input int w);
        int c;
        c = (code > w) ? w : code;
        return (256'd1 << c) - 256'd1;
    endfunction

    function automatic logic [254:0] exp255(input int code);
        logic [255:0] t;
        t = therm_ref(code, 255);
        return t[254:0];
    endfunction

    function automatic logic [199:0] exp200(input int code);
        logic [255:0] t;
        t = therm_ref(code, 200);
        return t[199:0];
    endfunction

    task automatic start_ramp(input int dw, input int code_noise);
        @(negedge clk);
        ramp_start = 1'b1;
        dwell      = 8'(dw);
        in_valid   = 1'b1;
        in_code    = 8'(code_noise);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL start_ready: in_ready=%b required 0", in_ready);
        end
        @(negedge clk);  // start edge E0 has passed: j = 0
        ramp_start = 1'b0;
        in_valid   = 1'b0;
        dwell      = 8'($urandom_range(0, 255)); // must be ignored after start
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (unary !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0 || ramp_busy !== 1'b0) begin
            fails++; $display("FAIL reset_init: unary_zero=%b ov=%b rdy=%b busy=%b required 1,0,0,0",
                              unary == '0, out_valid, in_ready, ramp_busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
        end
        // traffic, then reset mid-traffic
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_code  = 8'(100 + k);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (unary !== '0 || out_valid !== 1'b0 || sat !== 1'b0 || ramp_done !== 1'b0 || ramp_busy !== 1'b0 || in_ready !== 1'b0) begin
            fails++; $display("FAIL reset_mid_traffic: unary_zero=%b ov=%b sat=%b done=%b busy=%b rdy=%b required 1,0,0,0,0,0",
                              unary == '0, out_valid, sat, ramp_done, ramp_busy, in_ready);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || ramp_busy !== 1'b0) begin
            fails++; $display("FAIL reset_idle: rdy=%b busy=%b required 1,0", in_ready, ramp_busy);
        end
    endtask

    task automatic test_back_to_back();
        int codes[4] = '{0, 1, 128, 255};
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if (out_valid !== 1'b1 || sat !== 1'b0 || unary !== exp255(codes[k-1])) begin
                    fails++; $display("FAIL b2b_code%0d: ov=%b sat=%b unary=%h required ov=1 sat=0 unary=%h",
                                      codes[k-1], out_valid, sat, unary, exp255(codes[k-1]));
                end
            end
            if (k < 4) begin
                in_valid = 1'b1;
                in_code  = 8'(codes[k]);
                #1;
                checks++;
                if (in_ready !== 1'b1) begin
                    fails++; $display("FAIL b2b_ready: in_ready=%b required 1", in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || unary !== exp255(255)) begin
            fails++; $display("FAIL b2b_hold: ov=%b unary=%h required ov=0 all ones", out_valid, unary);
        end
    endtask

    task automatic test_random_direct();
        logic [254:0] exp_u;
        logic         exp_ov;
        exp_u  = unary;  // value left by previous test is the starting point
        exp_ov = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== exp_ov || sat !== 1'b0 || unary !== exp_u || ramp_busy !== 1'b0) begin
                fails++; $display("FAIL rand_direct[%0d]: ov=%b sat=%b busy=%b unary=%h required ov=%b sat=0 busy=0 unary=%h",
                                  k, out_valid, sat, ramp_busy, unary, exp_ov, exp_u);
            end
            in_valid   = 1'($urandom_range(0, 1));
            in_code    = 8'($urandom_range(0, 255));
            ramp_abort = 1'($urandom_range(0, 1)); // no effect in IDLE
            exp_ov     = in_valid;
            if (in_valid) exp_u = exp255(int'(in_code));
        end
        @(negedge clk);
        in_valid   = 1'b0;
        ramp_abort = 1'b0;
    endtask

    task automatic test_saturation();
        int codes[4] = '{230, 200, 199, 255};
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if (out_valid2 !== 1'b1 || sat2 !== (codes[k-1] > 200) || unary2 !== exp200(codes[k-1])) begin
                    fails++; $display("FAIL sat_code%0d: ov=%b sat=%b unary=%h required ov=1 sat=%b unary=%h",
                                      codes[k-1], out_valid2, sat2, unary2, codes[k-1] > 200, exp200(codes[k-1]));
                end
            end
            in_valid2 = (k < 4);
            in_code2  = (k < 4) ? 8'(codes[k]) : 8'd0;
        end
        @(negedge clk);
        checks++;
        if (sat2 !== 1'b0 || out_valid2 !== 1'b0) begin
            fails++; $display("FAIL sat_pulse_end: sat=%b ov=%b required 0,0", sat2, out_valid2);
        end
    endtask

    task automatic test_ramp(input int dw);
        int per, total, nbad, code;
        logic exp_ov, exp_done, exp_busy;
        per   = dw + 1;
        total = 256 * per;
        nbad  = 0;
        start_ramp(dw, 200);
        for (int j = 0; j <= total + 2; j++) begin
            code     = (j >= 1) ? (((j - 1) / per > 255) ? 255 : (j - 1) / per) : 0;
            exp_ov   = (j >= 1) && ((j - 1) % per == 0) && ((j - 1) / per <= 255);
            exp_done = (j == total);
            exp_busy = (j < total);
            checks++;
            if (out_valid !== exp_ov || ramp_done !== exp_done || ramp_busy !== exp_busy ||
                in_ready !== !exp_busy || sat !== 1'b0 || (j >= 1 && unary !== exp255(code))) begin
                fails++; nbad++;
                if (nbad <= 8)
                    $display("FAIL ramp_dw%0d_j%0d: ov=%b done=%b busy=%b rdy=%b unary=%h required ov=%b done=%b busy=%b code=%0d",
                             dw, j, out_valid, ramp_done, ramp_busy, in_ready, unary, exp_ov, exp_done, exp_busy, code);
                else
                    $display("FAIL ramp_dw%0d_j%0d", dw, j);
            end
            // direct traffic during the sweep must be ignored
            in_valid = (j < total) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_code  = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_priority();
        start_ramp(0, 200);
        checks++;
        if (out_valid !== 1'b0 || ramp_busy !== 1'b1) begin
            fails++; $display("FAIL prio_start: ov=%b busy=%b required 0,1", out_valid, ramp_busy);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || unary !== exp255(0)) begin
            fails++; $display("FAIL prio_first_code: ov=%b unary=%h required ov=1 code 0", out_valid, unary);
        end
        ramp_abort = 1'b1;
        @(negedge clk);
        ramp_abort = 1'b0;
        checks++;
        if (ramp_busy !== 1'b0 || out_valid !== 1'b0 || unary !== exp255(0)) begin
            fails++; $display("FAIL prio_abort: busy=%b ov=%b unary=%h required 0,0,code 0", ramp_busy, out_valid, unary);
        end
    endtask

    // Abort (or reset) while code 57 is held in DWELL with dwell=3.
    task automatic test_abort(input bit use_reset);
        int seen_done;
        start_ramp(3, 0);
        repeat (229) @(negedge clk);  // j = 229: code 57 just presented
        checks++;
        if (out_valid !== 1'b1 || unary !== exp255(57)) begin
            fails++; $display("FAIL abort_reach57: ov=%b unary=%h required ov=1 code 57", out_valid, unary);
        end
        @(negedge clk);               // j = 230: in DWELL
        if (use_reset) begin
            #2 rst_n = 1'b0;
            #1;
            checks++;
            if (unary !== '0 || ramp_busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || ramp_done !== 1'b0) begin
                fails++; $display("FAIL abort_reset57: unary_zero=%b busy=%b rdy=%b ov=%b done=%b required 1,0,0,0,0",
                                  unary == '0, ramp_busy, in_ready, out_valid, ramp_done);
            end
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            ramp_abort = 1'b1;
            @(negedge clk);
            ramp_abort = 1'b0;
            checks++;
            if (unary !== exp255(57) || ramp_busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || ramp_done !== 1'b0) begin
                fails++; $display("FAIL abort57: unary=%h busy=%b rdy=%b ov=%b done=%b required code 57,0,1,0,0",
                                  unary, ramp_busy, in_ready, out_valid, ramp_done);
            end
        end
        seen_done = 0;
        for (int k = 0; k < 1100; k++) begin
            @(negedge clk);
            if (ramp_done === 1'b1 || ramp_busy === 1'b1 || out_valid === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            fails++; $display("FAIL abort_quiet_rst%0d: activity cycles=%0d required 0", use_reset, seen_done);
        end
    endtask

    // Abort in the same cycle the final code would complete the sweep.
    task automatic test_abort_at_end();
        start_ramp(0, 0);
        repeat (255) @(negedge clk);  // j = 255: code 254 shown, RAMP holds counter 255
        ramp_abort = 1'b1;
        @(negedge clk);
        ramp_abort = 1'b0;
        checks++;
        if (ramp_done !== 1'b0 || out_valid !== 1'b0 || ramp_busy !== 1'b0 || unary !== exp255(254)) begin
            fails++; $display("FAIL abort_end: done=%b ov=%b busy=%b unary=%h required 0,0,0,code 254",
                              ramp_done, out_valid, ramp_busy, unary);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_random_direct();
        test_saturation();
        test_ramp(2);
        test_ramp(0);
        test_priority();
        test_abort(1'b0);
        test_abort(1'b1);
        test_abort_at_end();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
